// File: rtl/frame_buf_reader.sv
// rtl/frame_buf_reader.sv - frame buffer reader with credit-limited fetch and FWFT output FIFO
//
// Reads FRAME_LEN words per accepted frame request from a frame buffer and
// streams them downstream through a FIFO_DEPTH-entry first-word-fall-through FIFO.
// Read requests are only issued when the FIFO is certain to have room for the
// returned word, counting words still in flight from the buffer.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-low reset
//   start_l        active-low request to read one frame (ignored while busy)
//   buf_rdy        frame buffer holds readable data
//   rd_en_l        active-low per-word read request to the frame buffer
//   rd_data_valid  returned word valid (one cycle per word)
//   data_in        returned word
//   data_out       head-of-FIFO word presented downstream
//   out_valid      data_out holds a valid word
//   out_ready      downstream accepts; transfer = out_valid & out_ready
//   sof / eof      first / last word of the frame on data_out
//   busy           frame accepted and last transfer not yet complete
//   done           one-cycle pulse after the last transfer of a frame
//   ovf            sticky: a returned word arrived with no FIFO space
module frame_buf_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_l,
  input  logic                  buf_rdy,
  output logic                  rd_en_l,
  input  logic                  rd_data_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sof,
  output logic                  eof,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int QW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] LEN     = CW'(FRAME_LEN);
  localparam logic [CW-1:0] LAST    = CW'(FRAME_LEN - 1);
  localparam logic [QW-1:0] DEPTH_Q = QW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                state, next_state;
  logic [CW-1:0]         req_cnt, out_cnt;
  logic [QW-1:0]         outstanding, fifo_count;
  logic [QW:0]           credit;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  xfer, full, wr_en, accept, req, last_xfer, ret;

  // Words already buffered plus words requested but not yet returned.
  assign credit = {1'b0, fifo_count} + {1'b0, outstanding};
  // A return only retires an in-flight request if one exists; stray strobes
  // must not wrap the in-flight count.
  assign ret    = rd_data_valid && (outstanding != '0);

  always_comb begin
    next_state = state;
    out_valid  = (fifo_count != '0);
    xfer       = out_valid && out_ready;
    full       = (fifo_count == DEPTH_Q);
    wr_en      = rd_data_valid && (state != IDLE) && (!full || xfer);
    accept     = (state == IDLE) && !start_l && buf_rdy;
    // Request is held off during reset so the buffer never sees a read
    // from a frame that is being abandoned.
    req        = reset && (state == FETCH) && buf_rdy &&
                 (credit < {1'b0, DEPTH_Q}) && (req_cnt < LEN);
    rd_en_l    = !req;
    last_xfer  = (state == DRAIN) && xfer && (out_cnt == LAST);
    unique case (state)
      IDLE:    if (accept) next_state = FETCH;
      FETCH:   if (req && (req_cnt == LAST)) next_state = DRAIN;
      DRAIN:   if (last_xfer) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      req_cnt     <= '0;
      out_cnt     <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      done        <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      state <= next_state;
      done  <= last_xfer;

      if (accept) begin
        req_cnt     <= '0;
        out_cnt     <= '0;
        outstanding <= '0;
      end else begin
        if (req)  req_cnt <= req_cnt + CW'(1);
        if (xfer) out_cnt <= out_cnt + CW'(1);
        case ({req, ret})
          2'b10:   outstanding <= outstanding + QW'(1);
          2'b01:   outstanding <= outstanding - QW'(1);
          default: outstanding <= outstanding;
        endcase
      end

      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (xfer)  rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, xfer})
        2'b10:   fifo_count <= fifo_count + QW'(1);
        2'b01:   fifo_count <= fifo_count - QW'(1);
        default: fifo_count <= fifo_count;
      endcase

      if (rd_data_valid && full && !xfer) ovf <= 1'b1;
    end
  end

  // Storage needs no reset: out_valid gates every read of it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_in;
  end

  assign data_out = out_valid ? mem[rd_ptr] : '0;
  assign sof      = out_valid && (out_cnt == '0);
  assign eof      = out_valid && (out_cnt == LAST);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_frame_buf_reader.sv
// tb/tb_frame_buf_reader.sv - self-checking bench for frame_buf_reader
module tb_frame_buf_reader;

  localparam int DW  = 32;
  localparam int FL  = 8;
  localparam int FD  = 4;

  logic          clk, reset, start_l, buf_rdy, rd_en_l, rd_data_valid;
  logic [DW-1:0] data_in, data_out;
  logic          out_valid, out_ready, sof, eof, busy, done, ovf;

  frame_buf_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .start_l(start_l), .buf_rdy(buf_rdy),
    .rd_en_l(rd_en_l), .rd_data_valid(rd_data_valid), .data_in(data_in),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .sof(sof), .eof(eof), .busy(busy), .done(done), .ovf(ovf)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  bit            inject   = 0;
  logic [DW-1:0] inj_data = '0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame buffer model: one-cycle read latency, random word contents. Every
  // word it returns for a real request is queued as the expected output.
  initial begin : responder
    bit pend;
    logic [DW-1:0] w;
    rd_data_valid = 0;
    data_in = '0;
    forever begin
      @(negedge clk);
      pend = !rd_en_l;
      @(posedge clk); #1;
      if (pend) begin
        w = $urandom;
        data_in = w;
        rd_data_valid = 1;
        exp_q.push_back(w);
      end else if (inject) begin
        data_in = inj_data;
        rd_data_valid = 1;
        inject = 0;
      end else begin
        rd_data_valid = 0;
        data_in = $urandom;
      end
    end
  end

  // Runs one frame. hold: out_ready forced low for that many cycles after start.
  // stop_after>0 returns once that many transfers have been seen (abort test).
  task automatic frame(input string tag, input int ready_pct, input int hold,
                       input bit rnd_buf, input bit stall3, input bit poke,
                       input int inj_cyc, input int stop_after, input bit exp_ovf);
    int reqs, xf, dones, post, stall_cnt;
    logic [DW-1:0] w;
    reqs = 0; xf = 0; dones = 0; post = 0; stall_cnt = 0;
    @(posedge clk); #1;
    buf_rdy = 1; start_l = 0; out_ready = (hold > 0) ? 1'b0 : 1'b1;
    @(posedge clk); #1;
    start_l = 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (cyc == 0) check({tag, "_busy_start"}, busy, 1);
      if (!buf_rdy) check({tag, "_stall_rd_en_l"}, rd_en_l, 1);
      if (!rd_en_l) begin
        check({tag, "_credit"}, (reqs - xf) < FD, 1);
        reqs++;
      end
      if (hold > 0 && cyc == hold - 1) begin
        check({tag, "_hold_reqs"}, reqs, FD);
        check({tag, "_hold_ovf"}, ovf, inj_cyc >= 0);
      end
      if (inj_cyc >= 0 && cyc == inj_cyc) begin
        inj_data = ~exp_q[0];
        inject = 1;
      end
      if (inj_cyc >= 0 && cyc == inj_cyc + 2) begin
        check({tag, "_inj_ovf"}, ovf, 1);
        check({tag, "_inj_head"}, data_out, exp_q[0]);
      end
      if (out_valid && out_ready) begin
        check({tag, "_q_nonempty"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check({tag, "_data"}, data_out, w);
          check({tag, "_sof"}, sof, xf == 0);
          check({tag, "_eof"}, eof, xf == FL - 1);
        end
        xf++;
      end
      if (stop_after > 0 && xf == stop_after) return;
      if (done) begin
        dones++;
        check({tag, "_busy_at_done"}, busy, 0);
      end
      if (dones > 0) begin
        post++;
        if (post == 4) break;
      end
      @(posedge clk); #1;
      out_ready = (cyc + 1 < hold) ? 1'b0 : ($urandom_range(99) < ready_pct);
      if (stall3 && reqs >= 4 && stall_cnt < 3) begin
        buf_rdy = 0;
        stall_cnt++;
      end else if (rnd_buf) buf_rdy = ($urandom_range(3) != 0);
      else buf_rdy = 1;
      start_l = (poke && xf < FL - 1 && $urandom_range(3) == 0) ? 1'b0 : 1'b1;
    end
    start_l = 1; buf_rdy = 1; out_ready = 1;
    check({tag, "_reqs"}, reqs, FL);
    check({tag, "_xfers"}, xf, FL);
    check({tag, "_dones"}, dones, 1);
    check({tag, "_q_left"}, exp_q.size(), 0);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_ovf_end"}, ovf, exp_ovf);
  endtask

  initial begin : main
    reset = 0; start_l = 1; buf_rdy = 1; out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en_l", rd_en_l, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_sof", sof, 0);
    check("rst_eof", eof, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    @(posedge clk); #1;
    reset = 1;

    frame("basic", 100, 0, 0, 0, 0, -1, 0, 0);
    frame("backpr", 100, 12, 0, 0, 0, -1, 0, 0);
    frame("stall", 100, 0, 0, 1, 0, -1, 0, 0);
    for (int i = 0; i < 5; i++) frame("rand", 60, 0, 1, 0, 1, -1, 0, 0);

    frame("ovf", 100, 12, 0, 0, 0, 8, 0, 1);
    repeat (3) @(negedge clk);
    check("ovf_sticky", ovf, 1);

    frame("abort", 100, 0, 0, 0, 0, -1, 5, 1);
    @(posedge clk); #1; reset = 0;
    @(posedge clk); #1; reset = 1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_rd_en_l", rd_en_l, 1);
    check("abort_ovf", ovf, 0);
    repeat (2) begin
      @(negedge clk);
      check("abort_stray_ignored", out_valid, 0);
    end
    exp_q.delete();
    frame("restart", 100, 0, 0, 0, 0, -1, 0, 0);

    @(posedge clk); #1; buf_rdy = 0; start_l = 0;
    @(posedge clk); #1; start_l = 1; buf_rdy = 1;
    repeat (6) begin
      @(negedge clk);
      check("nostart_rd_en_l", rd_en_l, 1);
      check("nostart_busy", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_buf_reader.md
FRAME_BUF_READER -- requirements
Module: frame_buf_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the pixel/word width.
REQ-002 Parameter FRAME_LEN, default 8, SHALL set the words read per frame (range 1..65535).
REQ-003 Parameter FIFO_DEPTH, default 4, SHALL set the output buffer depth (power of 2, >=2).
REQ-004 clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-005 reset  input  1  SHALL be the synchronous, active-low reset.
REQ-006 start_l  input  1  SHALL be the active-low request to read one frame.
REQ-007 buf_rdy  input  1  SHALL be high while the frame buffer holds readable data.
REQ-008 rd_en_l  output  1  SHALL be the active-low per-word read request to the frame buffer.
REQ-009 rd_data_valid  input  1  SHALL be high for one cycle per returned word.
REQ-010 data_in  input  DATA_WIDTH  SHALL be the returned word, sampled when rd_data_valid=1.
REQ-011 data_out  output  DATA_WIDTH  SHALL be the word presented downstream.
REQ-012 out_valid  output  1  SHALL be high when data_out holds a valid word.
REQ-013 out_ready  input  1  SHALL be high when downstream accepts; transfer = out_valid & out_ready.
REQ-014 sof  output  1  SHALL be high with the first word of a frame while out_valid=1.
REQ-015 eof  output  1  SHALL be high with word FRAME_LEN-1 of a frame while out_valid=1.
REQ-016 busy  output  1  SHALL be high from frame acceptance until the last transfer completes.
REQ-017 done  output  1  SHALL pulse high for exactly one cycle after the last transfer.
REQ-018 ovf  output  1  SHALL be a sticky flag set on a returned word with no FIFO space.

Function
REQ-019 State machine SHALL have states IDLE, FETCH, DRAIN.
REQ-020 IDLE->FETCH SHALL occur when start_l=0 and buf_rdy=1; req_cnt, out_cnt, sof flag cleared; busy=1 next cycle.
REQ-021 start_l=0 with buf_rdy=0 SHALL be ignored (remain IDLE, no request latched).
REQ-022 In FETCH, rd_en_l SHALL be 0 in a cycle iff buf_rdy=1 and (fifo_count + outstanding) < FIFO_DEPTH and req_cnt < FRAME_LEN.
REQ-023 Each cycle with rd_en_l=0 SHALL increment req_cnt and outstanding by 1; each rd_data_valid=1 SHALL decrement outstanding by 1; simultaneous events net to zero change.
REQ-024 FETCH->DRAIN SHALL occur the cycle req_cnt reaches FRAME_LEN; no further rd_en_l=0 until next frame.
REQ-025 DRAIN->IDLE SHALL occur on the transfer of word FRAME_LEN-1; done=1 and busy=0 the following cycle.
REQ-026 FIFO SHALL be first-word-fall-through: data_out/out_valid reflect head entry; write on rd_data_valid, read on transfer, both in one cycle allowed (count unchanged).
REQ-027 data_out SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 out_cnt SHALL increment per transfer; sof = out_valid & (out_cnt==0); eof = out_valid & (out_cnt==FRAME_LEN-1).
REQ-029 Read pointers, write pointers and counters SHALL wrap modulo their width without carry into other state.
REQ-030 rd_data_valid=1 with fifo full and no same-cycle transfer SHALL drop data_in and set ovf; ovf clears only on reset.
REQ-031 rd_data_valid=1 in IDLE SHALL be ignored except for setting ovf.
REQ-032 start_l while busy=1 SHALL be ignored; no frame queuing.
REQ-033 buf_rdy falling mid-frame SHALL only stall requests; state and counters are held.

Reset
REQ-034 On clk edge with reset=0: state=IDLE, rd_en_l=1, out_valid=0, data_out=0, sof=0, eof=0, busy=0, done=0, ovf=0, all counters and FIFO pointers=0.
REQ-035 Reset mid-frame SHALL abandon the frame; FIFO contents discarded; rd_data_valid arriving after reset is ignored.

Verification
REQ-036 FRAME_LEN=8, buf_rdy=1, out_ready=1, 1-cycle return latency, start_l pulse -> 8 rd_en_l=0 cycles, words 0..7 in order, sof on word 0, eof on word 7, one done pulse.
REQ-037 out_ready=0 held after start -> exactly FIFO_DEPTH=4 rd_en_l=0 cycles, then rd_en_l=1 until out_ready=1; no ovf.
REQ-038 buf_rdy=0 for 3 cycles after word 3 requested -> rd_en_l=1 those cycles; output sequence 0..7 unchanged.
REQ-039 Inject extra rd_data_valid with FIFO full and out_ready=0 -> ovf=1, stored data unchanged, ovf stays 1 until reset.
REQ-040 reset=0 after word 4 transferred -> next cycle busy=0, out_valid=0, rd_en_l=1; new start yields words from out_cnt=0 with sof.
REQ-041 start_l=0 with buf_rdy=0, then start_l=1 -> no rd_en_l assertion, busy stays 0.
